// File: rtl/exe_mem_skid_reg_pkg.sv
// Shared definitions for the EXE/MEM skid register: occupancy states,
// status-register bit positions and default path widths.
package exe_mem_skid_reg_pkg;

  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_REG_ADDR_W = 4;

  localparam int SR_W = 4;
  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/exe_mem_skid_reg_status_reg.sv
// Load-enabled status register {N,Z,C,V} with synchronous active-high reset.
module status_reg
  import exe_mem_skid_reg_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [SR_W-1:0] d,
  output logic [SR_W-1:0] q
);

  // Status register: clear on reset, capture flags on load, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 4'b0000;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/exe_mem_skid_reg.sv
// Two-entry skid FIFO between EXE and MEM; in_ready and out_valid are
// registered so neither side sees a combinational path from the other.
module exe_mem_skid_reg
  import exe_mem_skid_reg_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_res,
  input  logic [SR_W-1:0]       status_bits,
  input  logic                  s_bit,
  input  logic                  wb_en,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  input  logic [DATA_W-1:0]     val_rm,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_alu_res,
  output logic [DATA_W-1:0]     out_val_rm,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic                  out_wb_en,
  output logic                  out_mem_r_en,
  output logic                  out_mem_w_en,
  output logic [SR_W-1:0]       sr,
  output logic                  sr_c
);

  occ_state_e state_r;
  occ_state_e state_next_s;
  logic       in_ready_r;
  logic       out_valid_r;
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic       push_s;
  logic       pop_s;
  logic       sr_load_s;

  logic [DATA_W-1:0]     alu_mem_r [2];
  logic [DATA_W-1:0]     rm_mem_r  [2];
  logic [REG_ADDR_W-1:0] dest_mem_r[2];
  logic [1:0]            wb_mem_r;
  logic [1:0]            mr_mem_r;
  logic [1:0]            mw_mem_r;

  // A push arriving with flush is dropped, and flush also blocks the pop.
  assign push_s    = in_valid & in_ready_r & ~flush;
  assign pop_s     = out_valid_r & out_ready & ~flush;
  assign sr_load_s = push_s & s_bit;

  // Occupancy next-state: push/pop bookkeeping, flush forces empty.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: state_next_s = push_s ? ST_ONE : ST_EMPTY;
        ST_ONE: begin
          if (push_s && !pop_s) begin
            state_next_s = ST_TWO;
          end else if (pop_s && !push_s) begin
            state_next_s = ST_EMPTY;
          end else begin
            state_next_s = ST_ONE;
          end
        end
        ST_TWO:   state_next_s = pop_s ? ST_ONE : ST_TWO;
        default:  state_next_s = ST_EMPTY;
      endcase
    end
  end

  // State, pointers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s != ST_TWO);
      out_valid_r <= (state_next_s != ST_EMPTY);
      if (flush) begin
        wr_ptr_r <= 1'b0;
        rd_ptr_r <= 1'b0;
      end else begin
        wr_ptr_r <= wr_ptr_r + {1'b0, push_s};
        rd_ptr_r <= rd_ptr_r + {1'b0, pop_s};
      end
    end
  end

  // Entry storage: written only on an accepted push, so a stalled head holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        alu_mem_r[i]  <= {DATA_W{1'b0}};
        rm_mem_r[i]   <= {DATA_W{1'b0}};
        dest_mem_r[i] <= {REG_ADDR_W{1'b0}};
      end
      wb_mem_r <= 2'b00;
      mr_mem_r <= 2'b00;
      mw_mem_r <= 2'b00;
    end else if (push_s) begin
      alu_mem_r[wr_ptr_r]  <= alu_res;
      rm_mem_r[wr_ptr_r]   <= val_rm;
      dest_mem_r[wr_ptr_r] <= dest;
      wb_mem_r[wr_ptr_r]   <= wb_en;
      mr_mem_r[wr_ptr_r]   <= mem_r_en;
      mw_mem_r[wr_ptr_r]   <= mem_w_en;
    end else begin
      wb_mem_r <= wb_mem_r;
      mr_mem_r <= mr_mem_r;
      mw_mem_r <= mw_mem_r;
    end
  end

  status_reg u_status_reg (
    .clk  (clk),
    .rst  (rst),
    .load (sr_load_s),
    .d    (status_bits),
    .q    (sr)
  );

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_alu_res  = alu_mem_r[rd_ptr_r];
  assign out_val_rm   = rm_mem_r[rd_ptr_r];
  assign out_dest     = dest_mem_r[rd_ptr_r];
  // Controls are gated so an empty buffer never triggers writeback or memory.
  assign out_wb_en    = out_valid_r & wb_mem_r[rd_ptr_r];
  assign out_mem_r_en = out_valid_r & mr_mem_r[rd_ptr_r];
  assign out_mem_w_en = out_valid_r & mw_mem_r[rd_ptr_r];
  assign sr_c         = sr[SR_C];

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Directed bench for exe_mem_skid_reg with a queue-based reference model
// compared on every falling edge, plus literal spot checks.
module tb_exe_mem_skid_reg;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, s_bit, wb_en, mem_r_en, mem_w_en;
  logic        flush, out_valid, out_ready;
  logic [31:0] alu_res, val_rm, out_alu_res, out_val_rm;
  logic [3:0]  status_bits, dest, out_dest, sr;
  logic        out_wb_en, out_mem_r_en, out_mem_w_en, sr_c;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rm;
    logic [3:0]  dest;
    logic        wb;
    logic        mr;
    logic        mw;
  } entry_t;

  entry_t     q[$];
  logic [3:0] sr_m;
  bit         started = 1'b0;
  int         checks = 0;
  int         errors = 0;

  exe_mem_skid_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_res(alu_res), .status_bits(status_bits), .s_bit(s_bit),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .val_rm(val_rm), .dest(dest), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_res(out_alu_res), .out_val_rm(out_val_rm), .out_dest(out_dest),
    .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en),
    .out_mem_w_en(out_mem_w_en), .sr(sr), .sr_c(sr_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of at most two entries plus the status register.
  always @(posedge clk) begin
    bit push, pop;
    entry_t e;
    started = 1'b1;
    if (rst) begin
      q.delete();
      sr_m = 4'b0000;
    end else if (flush) begin
      q.delete();
    end else begin
      push = in_valid && (q.size() < 2);
      pop  = (q.size() > 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (push) begin
        e = '{alu: alu_res, rm: val_rm, dest: dest, wb: wb_en, mr: mem_r_en, mw: mem_w_en};
        q.push_back(e);
        if (s_bit) sr_m = status_bits;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
      chk("m_sr", {28'd0, sr}, {28'd0, sr_m});
      chk("m_sr_c", {31'd0, sr_c}, {31'd0, sr_m[1]});
      if (q.size() > 0) begin
        chk("m_alu", out_alu_res, q[0].alu);
        chk("m_rm", out_val_rm, q[0].rm);
        chk("m_dest", {28'd0, out_dest}, {28'd0, q[0].dest});
        chk("m_ctl", {29'd0, out_wb_en, out_mem_r_en, out_mem_w_en},
            {29'd0, q[0].wb, q[0].mr, q[0].mw});
      end else begin
        chk("m_ctl_idle", {29'd0, out_wb_en, out_mem_r_en, out_mem_w_en}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] rm,
                       input logic [3:0] d, input logic [2:0] ctl);
    in_valid = v;
    alu_res  = a;
    val_rm   = rm;
    dest     = d;
    {wb_en, mem_r_en, mem_w_en} = ctl;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; s_bit = 1'b0; status_bits = 4'h0;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    step(); step();
    rst = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_sr", {28'd0, sr}, 32'd0);
    chk("rst_alu", out_alu_res, 32'd0);
    chk("rst_dest", {28'd0, out_dest}, 32'd0);

    // Single push, 1-cycle latency, then drain.
    out_ready = 1'b1;
    drive(1'b1, 32'h5, 32'h11, 4'd3, 3'b100);
    step();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_alu", out_alu_res, 32'h5);
    chk("lat_wb", {31'd0, out_wb_en}, 32'd1);
    step();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_wb", {31'd0, out_wb_en}, 32'd0);

    // Stall: A and B accepted, C held upstream, then released in order.
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 32'hA0, 4'd1, 3'b010); step();
    drive(1'b1, 32'hB, 32'hB0, 4'd2, 3'b001); step();
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'hC, 32'hC0, 4'd4, 3'b110); step();
    chk("stall_head", out_alu_res, 32'hA);
    chk("stall_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("rel_b", out_alu_res, 32'hB);
    step();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    chk("rel_c", out_alu_res, 32'hC);
    step();
    chk("rel_empty", {31'd0, out_valid}, 32'd0);

    // Status register load and hold.
    drive(1'b1, 32'h20, 32'h0, 4'd5, 3'b100);
    s_bit = 1'b1; status_bits = 4'b0110;
    step();
    chk("sr_load", {28'd0, sr}, 32'h6);
    chk("sr_c", {31'd0, sr_c}, 32'd1);
    s_bit = 1'b0; status_bits = 4'b1001;
    step();
    chk("sr_hold", {28'd0, sr}, 32'h6);
    drive(1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    step();

    // Flush in TWO with a push attempt carrying flags.
    out_ready = 1'b0;
    drive(1'b1, 32'h31, 32'h1, 4'd6, 3'b011); step();
    drive(1'b1, 32'h32, 32'h2, 4'd7, 3'b011); step();
    flush = 1'b1; s_bit = 1'b1; status_bits = 4'b1111;
    step();
    flush = 1'b0; s_bit = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    chk("fl2_valid", {31'd0, out_valid}, 32'd0);
    chk("fl2_sr", {28'd0, sr}, 32'h6);
    chk("fl2_ctl", {29'd0, out_wb_en, out_mem_r_en, out_mem_w_en}, 32'd0);

    // Flush in ONE coinciding with an accepted-looking push: push dropped.
    drive(1'b1, 32'h41, 32'h0, 4'd8, 3'b100); step();
    drive(1'b1, 32'h42, 32'h0, 4'd9, 3'b100);
    flush = 1'b1; s_bit = 1'b1; status_bits = 4'b1111; out_ready = 1'b1;
    step();
    flush = 1'b0; s_bit = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    chk("fl1_valid", {31'd0, out_valid}, 32'd0);
    chk("fl1_sr", {28'd0, sr}, 32'h6);
    step();

    // Reset in the middle of a stall, then resume.
    out_ready = 1'b0;
    drive(1'b1, 32'h51, 32'h5, 4'd2, 3'b100); step();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 3'b000); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_sr", {28'd0, sr}, 32'd0);
    chk("mrst_alu", out_alu_res, 32'd0);
    drive(1'b1, 32'h61, 32'h6, 4'd3, 3'b001); step();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    chk("resume_alu", out_alu_res, 32'h61);
    out_ready = 1'b1;
    step();

    // Streaming push+pop in ONE across pointer wrap.
    drive(1'b1, 32'h100, 32'h200, 4'd0, 3'b100); step();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'h100 + i, 32'h200 + i, i[3:0], {i[0], i[1], i[2]});
      step();
      chk("str_alu", out_alu_res, 32'h100 + i);
      chk("str_ready", {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    step(); step();
    chk("end_empty", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
